// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and (optionally) high time of an
// asynchronous clock/gate signal in Clock_in cycles, and flags loss of signal.
//
// Optional feature: define DUTY_MEASURE_EN to build the high-time counter.
// Without it, high_time is tied to 0 and the rest behaves identically.
//
// Ports:
//   Clock_in   in   measurement clock
//   reset      in   synchronous, active-high reset
//   sig_in     in   asynchronous signal under test
//   period     out  cycles between the last two rising edges
//   high_time  out  cycles high in the last completed period
//   meas_valid out  one-cycle pulse when period/high_time update
//   sig_lost   out  level: no rising edge for TIMEOUT_CYCLES
module clock_period_meter #(
  parameter int CNT_WIDTH      = 18,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 Clock_in,
  input  logic                 reset,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 sig_lost
);

  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURE,
    LOST
  } state_t;

  // ---------------------------------------------------------------
  // Synchroniser and edge detect
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   sync_last;
  logic                   rise;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last & ~prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d = sync_last;
  end

  // ---------------------------------------------------------------
  // Period counter and measurement FSM
  // ---------------------------------------------------------------
  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] period_d;
  logic                 meas_valid_q;
  logic                 meas_valid_d;
  logic                 sig_lost_q;
  logic                 sig_lost_d;
  logic                 cnt_sat;
  logic                 take;

  // cnt parks at the timeout value so a dead input never wraps
  // around into a bogus short period.
  assign cnt_sat = (cnt_q == TMO);

  // A rise while measuring closes the interval; this has priority
  // over the timeout, so a rise landing exactly on TMO is valid.
  assign take = rise && (state_q == MEASURE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_sat ? cnt_q : cnt_q + ONE;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    sig_lost_d   = sig_lost_q;
    unique case (state_q)
      WAIT_FIRST: begin
        if (rise) begin
          cnt_d   = ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d     = cnt_q;
          meas_valid_d = 1'b1;
          cnt_d        = ONE;
        end else if (cnt_sat) begin
          sig_lost_d = 1'b1;
          state_d    = LOST;
        end
      end
      LOST: begin
        // Interval ending here spans the outage: restart only.
        if (rise) begin
          sig_lost_d = 1'b0;
          cnt_d      = ONE;
          state_d    = MEASURE;
        end
      end
      default: begin
        state_d = WAIT_FIRST;
      end
    endcase
  end

  always_ff @(posedge Clock_in) begin
    if (reset) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      state_q      <= WAIT_FIRST;
      cnt_q        <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      sig_lost_q   <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      sig_lost_q   <= sig_lost_d;
    end
  end

  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign sig_lost   = sig_lost_q;

  // ---------------------------------------------------------------
  // High-time measurement
  // ---------------------------------------------------------------
`ifdef DUTY_MEASURE_EN
  logic                 fall;
  logic [CNT_WIDTH-1:0] hi_cnt_q;
  logic [CNT_WIDTH-1:0] hi_cnt_d;
  logic [CNT_WIDTH-1:0] hi_hold_q;
  logic [CNT_WIDTH-1:0] hi_hold_d;
  logic                 fall_seen_q;
  logic                 fall_seen_d;
  logic [CNT_WIDTH-1:0] high_time_q;
  logic [CNT_WIDTH-1:0] high_time_d;

  assign fall = ~sync_last & prev_q;

  always_comb begin
    hi_cnt_d    = hi_cnt_q;
    hi_hold_d   = hi_hold_q;
    fall_seen_d = fall_seen_q;
    high_time_d = high_time_q;
    if (rise) begin
      hi_cnt_d    = ONE;
      fall_seen_d = 1'b0;
    end else begin
      if (sync_last && (hi_cnt_q != TMO)) begin
        hi_cnt_d = hi_cnt_q + ONE;
      end
      if (fall) begin
        hi_hold_d   = hi_cnt_q;
        fall_seen_d = 1'b1;
      end
    end
    // Without a fall in the interval the signal was high throughout.
    if (take) begin
      high_time_d = fall_seen_q ? hi_hold_q : cnt_q;
    end
  end

  always_ff @(posedge Clock_in) begin
    if (reset) begin
      hi_cnt_q    <= '0;
      hi_hold_q   <= '0;
      fall_seen_q <= 1'b0;
      high_time_q <= '0;
    end else begin
      hi_cnt_q    <= hi_cnt_d;
      hi_hold_q   <= hi_hold_d;
      fall_seen_q <= fall_seen_d;
      high_time_q <= high_time_d;
    end
  end

  assign high_time = high_time_q;
`else
  logic unused_take;
  assign unused_take = take;
  assign high_time   = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Testbench for clock_period_meter: drives sig_in patterns and checks
// every cycle against an interval-arithmetic reference model.
module tb_clock_period_meter;

  localparam int CW  = 18;
  localparam int TMO = 100;
  localparam int SS  = 2;
  localparam int OW  = 2 * CW + 2;
  // sig_in change to registered output: SS sync flops + edge + output reg
  localparam int LAT = SS + 1;

  logic          Clock_in;
  logic          reset;
  logic          sig_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          sig_lost;

  int n_cmp = 0;
  int n_bad = 0;

  bit            stim[$];
  logic [OW-1:0] obs[$];
  logic [OW-1:0] exp_q[$];

  clock_period_meter #(
    .CNT_WIDTH     (CW),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (SS)
  ) dut (
    .Clock_in  (Clock_in),
    .reset     (reset),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .sig_lost  (sig_lost)
  );

  initial Clock_in = 1'b0;
  always #5 Clock_in = ~Clock_in;

  // ---------------- stimulus helpers ----------------
  task automatic add_pulses(input int hi, input int lo, input int cnt);
    repeat (cnt) begin
      repeat (hi) stim.push_back(1'b1);
      repeat (lo) stim.push_back(1'b0);
    end
  endtask

  task automatic add_level(input bit v, input int cnt);
    repeat (cnt) stim.push_back(v);
  endtask

  task automatic apply_reset(input int k, output logic any);
    any = 1'b0;
    reset = 1'b1;
    repeat (k) begin
      sig_in = ~sig_in;
      @(posedge Clock_in);
      #1;
      any = any | meas_valid | sig_lost | (|period) | (|high_time);
    end
  endtask

  // Releases reset and plays stim; obs[n] is sampled before stim[n].
  task automatic play();
    obs.delete();
    reset = 1'b0;
    foreach (stim[n]) begin
      obs.push_back({meas_valid, sig_lost, period, high_time});
      sig_in = stim[n];
      @(posedge Clock_in);
      #1;
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the list of rising edges in stim: each pair of
  // consecutive rises is either a measured interval (gap <= TMO)
  // or an outage flagged TMO cycles after the older rise.
  task automatic build_exp();
    int len;
    int r[$];
    int per[];
    int hi[];
    bit vl[];
    bit ls[];
    int g;
    int h;
    int t;
    int cur_p;
    int cur_h;
    len = stim.size();
    per = new[len];
    hi  = new[len];
    vl  = new[len];
    ls  = new[len];
    for (int n = 0; n < len; n++) begin
      vl[n] = 1'b0;
      ls[n] = 1'b0;
      if (stim[n] && (n == 0 || !stim[n-1])) r.push_back(n);
    end
    for (int i = 1; i < r.size(); i++) begin
      g = r[i] - r[i-1];
      if (g <= TMO) begin
        h = 0;
        for (int k = r[i-1]; k < r[i]; k++) h += int'(stim[k]);
        t = r[i] + LAT;
        if (t < len) begin
          vl[t]  = 1'b1;
          per[t] = g;
          hi[t]  = h;
        end
      end else begin
        for (int n = r[i-1] + TMO + LAT; n < r[i] + LAT && n < len; n++)
          ls[n] = 1'b1;
      end
    end
    if (r.size() > 0) begin
      for (int n = r[r.size()-1] + TMO + LAT; n < len; n++) ls[n] = 1'b1;
    end
    exp_q.delete();
    cur_p = 0;
    cur_h = 0;
    for (int n = 0; n < len; n++) begin
      if (vl[n]) begin
        cur_p = per[n];
`ifdef DUTY_MEASURE_EN
        cur_h = hi[n];
`endif
      end
      exp_q.push_back({vl[n], ls[n], CW'(cur_p), CW'(cur_h)});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic any;
    int nv;
    apply_reset(5, any);
    n_cmp++;
    if (any !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b exp=0", any);
    end
    stim.delete();
    add_pulses(10, 10, 4);
    build_exp();
    play();
    nv = 0;
    for (int n = 0; n < 20 + LAT; n++) nv += int'(obs[n][OW-1]);
    n_cmp++;
    if (nv !== 0) begin
      n_bad++;
      $display("FAIL first_rise_valid got=%0d exp=0", nv);
    end
    foreach (exp_q[n]) begin
      n_cmp++;
      if (obs[n] !== exp_q[n]) begin
        n_bad++;
        $display("FAIL reset_seq cyc=%0d got=%h exp=%h", n, obs[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_period_20();
    logic any;
    int nv;
    apply_reset(3, any);
    stim.delete();
    add_level(1'b0, 3);
    add_pulses(10, 10, 10);
    build_exp();
    play();
    nv = 0;
    foreach (obs[n]) nv += int'(obs[n][OW-1]);
    n_cmp++;
    if (nv !== 9) begin
      n_bad++;
      $display("FAIL p20_count got=%0d exp=9", nv);
    end
    foreach (exp_q[n]) begin
      n_cmp++;
      if (obs[n] !== exp_q[n]) begin
        n_bad++;
        $display("FAIL p20 cyc=%0d got=%h exp=%h", n, obs[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_period_7();
    logic any;
    logic [CW-1:0] want_h;
    apply_reset(3, any);
    stim.delete();
    add_pulses(3, 4, 12);
    build_exp();
    play();
`ifdef DUTY_MEASURE_EN
    want_h = CW'(3);
`else
    want_h = '0;
`endif
    n_cmp++;
    if (obs[7+LAT] !== {1'b1, 1'b0, CW'(7), want_h}) begin
      n_bad++;
      $display("FAIL p7_latency got=%h exp=%h", obs[7+LAT],
               {1'b1, 1'b0, CW'(7), want_h});
    end
    foreach (exp_q[n]) begin
      n_cmp++;
      if (obs[n] !== exp_q[n]) begin
        n_bad++;
        $display("FAIL p7 cyc=%0d got=%h exp=%h", n, obs[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_timeout_resume();
    logic any;
    apply_reset(3, any);
    stim.delete();
    add_pulses(10, 10, 5);
    add_level(1'b0, 150);
    add_pulses(10, 10, 4);
    build_exp();
    play();
    n_cmp++;
    if ({obs[182][OW-2], obs[183][OW-2]} !== 2'b01
        || obs[183][2*CW-1:CW] !== CW'(20)) begin
      n_bad++;
      $display("FAIL lost_onset got=%b%b/%0d exp=01/20",
               obs[182][OW-2], obs[183][OW-2], obs[183][2*CW-1:CW]);
    end
    n_cmp++;
    if ({obs[252][OW-2], obs[253][OW-2], obs[253][OW-1], obs[273][OW-1]}
        !== 4'b1001) begin
      n_bad++;
      $display("FAIL resume got=%b%b%b%b exp=1001", obs[252][OW-2],
               obs[253][OW-2], obs[253][OW-1], obs[273][OW-1]);
    end
    foreach (exp_q[n]) begin
      n_cmp++;
      if (obs[n] !== exp_q[n]) begin
        n_bad++;
        $display("FAIL tmo cyc=%0d got=%h exp=%h", n, obs[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_stuck_high();
    logic any;
    apply_reset(3, any);
    stim.delete();
    add_pulses(10, 10, 3);
    add_level(1'b1, 150);
    build_exp();
    play();
    n_cmp++;
    if ({obs[162][OW-2], obs[163][OW-2]} !== 2'b01) begin
      n_bad++;
      $display("FAIL stuck_high got=%b%b exp=01",
               obs[162][OW-2], obs[163][OW-2]);
    end
    foreach (exp_q[n]) begin
      n_cmp++;
      if (obs[n] !== exp_q[n]) begin
        n_bad++;
        $display("FAIL stuck cyc=%0d got=%h exp=%h", n, obs[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_boundary_gap();
    logic any;
    apply_reset(3, any);
    stim.delete();
    add_pulses(40, 60, 3);
    add_pulses(40, 61, 2);
    add_pulses(1, 1, 6);
    add_pulses(5, 5, 3);
    build_exp();
    play();
    n_cmp++;
    if (obs[100+LAT][OW-1:OW-2] !== 2'b10
        || obs[100+LAT][2*CW-1:CW] !== CW'(100)) begin
      n_bad++;
      $display("FAIL gap_eq_tmo got=%h exp_period=100", obs[100+LAT]);
    end
    n_cmp++;
    if ({obs[402][OW-2], obs[403][OW-2], obs[404][OW-2]} !== 3'b010) begin
      n_bad++;
      $display("FAIL gap_tmo_plus1 got=%b%b%b exp=010",
               obs[402][OW-2], obs[403][OW-2], obs[404][OW-2]);
    end
    foreach (exp_q[n]) begin
      n_cmp++;
      if (obs[n] !== exp_q[n]) begin
        n_bad++;
        $display("FAIL bound cyc=%0d got=%h exp=%h", n, obs[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic any;
    int lo;
    apply_reset(2, any);
    stim.delete();
    add_level(1'b0, $urandom_range(0, 5));
    repeat (40) begin
      if ($urandom_range(0, 7) == 0) lo = $urandom_range(85, 110);
      else lo = $urandom_range(1, 12);
      add_pulses($urandom_range(1, 12), lo, 1);
    end
    build_exp();
    play();
    foreach (exp_q[n]) begin
      n_cmp++;
      if (obs[n] !== exp_q[n]) begin
        n_bad++;
        $display("FAIL rand cyc=%0d got=%h exp=%h", n, obs[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic any;
    apply_reset(3, any);
    stim.delete();
    add_pulses(10, 10, 2);
    add_level(1'b1, 5);
    build_exp();
    play();
    foreach (exp_q[n]) begin
      n_cmp++;
      if (obs[n] !== exp_q[n]) begin
        n_bad++;
        $display("FAIL mid_pre cyc=%0d got=%h exp=%h", n, obs[n], exp_q[n]);
      end
    end
    apply_reset(2, any);
    n_cmp++;
    if (any !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs got=%b exp=0", any);
    end
    stim.delete();
    add_level(1'b0, 4);
    add_pulses(6, 7, 4);
    build_exp();
    play();
    foreach (exp_q[n]) begin
      n_cmp++;
      if (obs[n] !== exp_q[n]) begin
        n_bad++;
        $display("FAIL mid_post cyc=%0d got=%h exp=%h", n, obs[n], exp_q[n]);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    test_reset();
    test_period_20();
    test_period_7();
    test_timeout_resume();
    test_stuck_high();
    test_boundary_gap();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
